mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the CPU's instruction-fetch port (read-only) and its load/store port (read/write).
- Registered arbiter FSM; supports variable-latency memory via mem_ack.
- Data has priority over fetch, with an anti-starvation limit on consecutive data grants.
- Sits between the CPU core and the memory macro; replaces separate instruction/data memories for multi-cycle core builds.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data word width.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is pending; range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched word; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1=store, 0=load; stable with d_req.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load result; valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory access strobe; held until mem_ack.
- mem_we  out  1  memory write enable; qualified by mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  access complete; may assert in the first mem_req cycle.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, streak=0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata.
  - Reset mid-access abandons the transfer: no ready pulse, mem_req drops immediately.
- States: IDLE, FETCH, DATA, RESP.
- IDLE:
  - Arbitrate on the current if_req/d_req.
  - Winner's address, we and wdata are registered onto mem_* at the next edge, and mem_req goes to 1.
  - The fetch path always drives mem_we=0 and mem_wdata=0.
- Arbitration:
  - d_req only -> DATA.
  - if_req only -> FETCH.
  - Both high -> DATA, unless streak==MAX_DATA_STREAK, in which case FETCH.
- Streak counter:
  - Increments on each DATA grant made while if_req=1; saturates at MAX_DATA_STREAK.
  - Clears on any FETCH grant.
  - Unchanged on a DATA grant with if_req=0.
- FETCH/DATA:
  - mem_req, mem_addr, mem_we and mem_wdata are held constant until mem_ack=1.
  - When mem_ack=1: capture mem_rdata into if_rdata or d_rdata, clear mem_req and mem_we, go to RESP.
  - For a store, d_rdata is loaded with mem_rdata anyway; it has no meaning.
- RESP:
  - Exactly one of if_ready/d_ready is high for one cycle.
  - Requests are ignored in this state; next state is IDLE.
  - The requester must drop or replace its request at the edge where ready is seen.
- Latency:
  - Request seen at edge N; mem_req high from cycle N+1.
  - If mem_ack arrives in cycle N+1+k, ready is high in cycle N+2+k.
  - Minimum request-to-ready is 2 cycles; minimum issue interval is 3 cycles.
- Data holding: if_rdata and d_rdata hold their last captured value until the next capture on their own path.
- Boundaries:
  - mem_ack while in IDLE or RESP is ignored.
  - Both requests high every cycle gives a repeating pattern of MAX_DATA_STREAK data grants followed by 1 fetch grant.
  - Request inputs are sampled only in IDLE.

Decomposition:
- Package mem_arb_pkg holds the state enum (IDLE=2'd0, FETCH=2'd1, DATA=2'd2, RESP=2'd3) and the default widths.
- One natural sub-module, arb_streak_counter: saturating counter with inc, clr and the MAX_DATA_STREAK compare.
- The remainder of the block stays flat.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10; mem_ack in the first mem_req cycle with mem_rdata=0x00500093 -> mem_addr=0x10 and mem_we=0; if_ready at cycle N+2 with if_rdata=0x00500093.
- Store with wait states: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF; mem_ack delayed 3 cycles -> mem_req, mem_we, mem_addr and mem_wdata stable for 4 cycles; d_ready at N+5; if_ready stays 0.
- Simultaneous requests: if_req=d_req=1 at the same edge -> data is granted first; fetch is granted in the IDLE that follows the data RESP.
- Starvation limit: both requests held continuously with MAX_DATA_STREAK=4 -> grant sequence D,D,D,D,F,D,D,D,D,F.
- Reset mid-access: assert reset while in DATA with mem_req=1 -> mem_req and d_ready go to 0 immediately; after release the state is IDLE and a subsequent fetch completes normally.
- Spurious ack: mem_ack=1 in IDLE with no requests -> no ready pulse, rdata outputs unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MAX_STREAK = 4;
    localparam int STREAK_W       = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// CPU fetch/load-store ports plus the memory-macro port, bundled for the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb_streak_counter.sv
// Counts consecutive data grants taken while fetch waits; saturates at MAX.
module arb_streak_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX = DEF_MAX_STREAK
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    logic [STREAK_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != STREAK_W'(MAX))
            cnt <= cnt + 1'b1;
    end

    assign at_max = (cnt == STREAK_W'(MAX));
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data beats fetch, except when fetch has waited
// through MAX_DATA_STREAK data grants in a row.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_DATA_STREAK = DEF_MAX_STREAK
) (
    input logic         clock,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    arb_state_e        state_q, state_d;
    logic              grant_d, grant_f, at_max;
    logic              mem_req, mem_we, if_ready, d_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, if_rdata, d_rdata;

    arb_streak_counter #(.MAX(MAX_DATA_STREAK)) u_streak (
        .clock  (clock),
        .reset  (reset),
        .inc    (grant_d & bus.if_req),
        .clr    (grant_f),
        .at_max (at_max)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant_d = 1'b0;
        grant_f = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && at_max)) begin
                    grant_d = 1'b1;
                    state_d = DATA;
                end else if (bus.if_req) begin
                    grant_f = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH, DATA: if (bus.mem_ack) state_d = RESP;
            RESP:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // mem_addr/mem_wdata are left as-is after completion; only req/we drop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= bus.d_we;
                        mem_addr  <= bus.d_addr;
                        mem_wdata <= bus.d_wdata;
                    end else if (grant_f) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= bus.if_addr;
                        mem_wdata <= '0;
                    end
                end
                FETCH: if (bus.mem_ack) begin
                    if_rdata <= bus.mem_rdata;
                    if_ready <= 1'b1;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                end
                DATA: if (bus.mem_ack) begin
                    d_rdata <= bus.mem_rdata;
                    d_ready <= 1'b1;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_ready  = if_ready;
    assign bus.d_ready   = d_ready;
    assign bus.if_rdata  = if_rdata;
    assign bus.d_rdata   = d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vec_cnt = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    string pat;

    initial begin
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 0;

        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_ready", 32'(bus.if_ready), 0);
        chk("rst_d_ready", 32'(bus.d_ready), 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        reset = 0;
        tick();

        // single fetch, ack in first mem_req cycle
        bus.if_req = 1; bus.if_addr = 32'h10; bus.mem_ack = 1; bus.mem_rdata = 32'h00500093;
        tick();
        chk("f1_mem_req", 32'(bus.mem_req), 1);
        chk("f1_mem_addr", bus.mem_addr, 32'h10);
        chk("f1_mem_we", 32'(bus.mem_we), 0);
        chk("f1_if_ready_early", 32'(bus.if_ready), 0);
        tick();
        chk("f1_if_ready", 32'(bus.if_ready), 1);
        chk("f1_if_rdata", bus.if_rdata, 32'h00500093);
        chk("f1_mem_req_drop", 32'(bus.mem_req), 0);
        bus.if_req = 0; bus.mem_ack = 0;
        tick();
        chk("f1_if_ready_pulse", 32'(bus.if_ready), 0);

        // store with 3 wait states
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("st_mem_req", 32'(bus.mem_req), 1);
            chk("st_mem_we", 32'(bus.mem_we), 1);
            chk("st_mem_addr", bus.mem_addr, 32'h200);
            chk("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
            chk("st_d_ready_wait", 32'(bus.d_ready), 0);
            if (i == 3) begin bus.mem_ack = 1; bus.mem_rdata = 32'h12345678; end
            tick();
        end
        chk("st_d_ready", 32'(bus.d_ready), 1);
        chk("st_if_ready", 32'(bus.if_ready), 0);
        chk("st_d_rdata", bus.d_rdata, 32'h12345678);
        chk("st_mem_req_drop", 32'(bus.mem_req), 0);
        chk("st_mem_we_drop", 32'(bus.mem_we), 0);
        bus.d_req = 0; bus.d_we = 0; bus.mem_ack = 0;
        tick();

        // simultaneous requests: data first, fetch after data RESP
        bus.if_req = 1; bus.if_addr = 32'h40; bus.d_req = 1; bus.d_addr = 32'h300;
        bus.mem_ack = 1; bus.mem_rdata = 32'h0000A5A5;
        tick();
        chk("sim_first_addr", bus.mem_addr, 32'h300);
        tick();
        chk("sim_d_ready", 32'(bus.d_ready), 1);
        chk("sim_d_rdata", bus.d_rdata, 32'h0000A5A5);
        bus.d_req = 0;
        tick();
        chk("sim_idle_mem_req", 32'(bus.mem_req), 0);
        tick();
        chk("sim_second_addr", bus.mem_addr, 32'h40);
        tick();
        chk("sim_if_ready", 32'(bus.if_ready), 1);
        chk("sim_if_rdata", bus.if_rdata, 32'h0000A5A5);
        bus.if_req = 0;
        tick();

        // starvation limit with both requests held
        pat = "DDDDFDDDDF";
        bus.if_req = 1; bus.d_req = 1; bus.mem_ack = 1;
        for (int g = 0; g < 10; g++) begin
            tick();
            chk("stv_grant_addr", bus.mem_addr, (pat[g] == "D") ? 32'h300 : 32'h40);
            tick();
            chk("stv_ready", {30'd0, bus.if_ready, bus.d_ready},
                (pat[g] == "D") ? 32'd1 : 32'd2);
            tick();
        end
        bus.if_req = 0; bus.d_req = 0; bus.mem_ack = 0;
        tick();

        // reset mid-access
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h80; bus.d_wdata = 32'h55;
        tick();
        chk("rma_mem_req_pre", 32'(bus.mem_req), 1);
        #2 reset = 1;
        #1;
        chk("rma_mem_req", 32'(bus.mem_req), 0);
        chk("rma_d_ready", 32'(bus.d_ready), 0);
        chk("rma_mem_we", 32'(bus.mem_we), 0);
        bus.d_req = 0; bus.d_we = 0;
        tick();
        chk("rma_d_ready_hold", 32'(bus.d_ready), 0);
        reset = 0;
        tick();
        bus.if_req = 1; bus.if_addr = 32'h20; bus.mem_ack = 1; bus.mem_rdata = 32'h13;
        tick();
        chk("rma_fetch_req", 32'(bus.mem_req), 1);
        chk("rma_fetch_addr", bus.mem_addr, 32'h20);
        tick();
        chk("rma_if_ready", 32'(bus.if_ready), 1);
        chk("rma_if_rdata", bus.if_rdata, 32'h13);
        chk("rma_no_d_ready", 32'(bus.d_ready), 0);
        bus.if_req = 0; bus.mem_ack = 0;
        tick();

        // spurious ack in IDLE
        bus.mem_ack = 1; bus.mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sp_if_ready", 32'(bus.if_ready), 0);
            chk("sp_d_ready", 32'(bus.d_ready), 0);
            chk("sp_mem_req", 32'(bus.mem_req), 0);
        end
        chk("sp_if_rdata", bus.if_rdata, 32'h13);
        chk("sp_d_rdata", bus.d_rdata, 32'h0);
        bus.mem_ack = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end
endmodule
